fir_magnitude: RTL and testbench
================================

Name: fir_magnitude

Overview:
- Converts the 17-bit two's-complement FIR accumulator result into a 16-bit unsigned magnitude (absolute value) for the output register path.
- Registered, 1-cycle latency, with valid qualification.
- Saturates the single unrepresentable case and keeps sticky saturation and peak-magnitude status for software readback.

Parameters:
- IN_WIDTH, 17, width of the signed input sample (two's complement, MSB = sign).
- OUT_WIDTH, 16, width of the unsigned magnitude output; IN_WIDTH must equal OUT_WIDTH+1.

Ports:
- clk  input  1  system clock, rising-edge active.
- n_rst  input  1  asynchronous active-low reset.
- in  input  IN_WIDTH  signed sample from the FIR output register.
- in_valid  input  1  qualifies `in` this cycle.
- clear  input  1  synchronous clear of `sat_sticky` and `peak`.
- out  output  OUT_WIDTH  registered magnitude of the last valid sample.
- out_valid  output  1  pulses high the cycle after an accepted sample.
- sat  output  1  high with `out_valid` when the current result was saturated.
- sat_sticky  output  1  set by any saturation; held until `clear` or reset.
- peak  output  OUT_WIDTH  largest `out` value produced since last `clear` or reset.

Behaviour:
- Interface: one clock `clk`, reset `n_rst` asynchronous active-low. All state resets immediately when `n_rst` is low, independent of `clk`.
- Reset values: `out` = 0, `out_valid` = 0, `sat` = 0, `sat_sticky` = 0, `peak` = 0.
- Magnitude rule, computed combinationally from `in`:
  - If `in[IN_WIDTH-1]` = 0: mag = `in[OUT_WIDTH-1:0]`.
  - Otherwise: mag = (~in + 1) truncated to IN_WIDTH bits, taking the low OUT_WIDTH bits.
- Saturation: when `in` = 1 followed by all zeros (17'h10000, i.e. -65536), the true magnitude 65536 does not fit. Result is all ones (16'hFFFF) and sat_now = 1. This is the only saturating input.
- On a rising edge with `in_valid` = 1:
  - `out` <= mag.
  - `sat` <= sat_now.
  - `out_valid` <= 1.
  - If mag > `peak`, `peak` <= mag.
  - If sat_now, `sat_sticky` <= 1.
- On a rising edge with `in_valid` = 0:
  - `out` and `peak` hold.
  - `out_valid` <= 0 and `sat` <= 0.
- Latency: exactly 1 cycle. Back-to-back `in_valid` gives back-to-back `out_valid` with no bubbles; throughput is one sample per cycle.
- `clear` on a rising edge:
  - `sat_sticky` <= 0 and `peak` <= 0.
  - If `in_valid` is also high that cycle, the new sample's update wins: `peak` <= mag, and `sat_sticky` <= sat_now.
  - `clear` does not affect `out`, `out_valid` or `sat`.
- Reset asserted mid-stream drops any in-flight result; `out_valid` stays 0 until the first valid sample after reset release.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold `n_rst` low with `in` = 17'h0D6B5 and `in_valid` = 1 -> `out` = 0, `out_valid` = 0, `peak` = 0, `sat_sticky` = 0. Assert `n_rst` low asynchronously between clock edges -> outputs clear immediately.
- Positive input: `in` = 17'b01101011010110101 (17'h0D6B5), `in_valid` = 1 -> next cycle `out` = 16'hD6B5, `out_valid` = 1, `sat` = 0.
- Negative input: `in` = 17'b10101010101010101 (17'h15555 = -43691) -> `out` = 16'hAAAB. `in` = 17'h1FFFF -> `out` = 16'h0001. `in` = 0 -> `out` = 0.
- Saturation: `in` = 17'h10000 -> `out` = 16'hFFFF, `sat` = 1 for one cycle, `sat_sticky` = 1 and held. Following sample 17'h00001 -> `out` = 1, `sat` = 0, `sat_sticky` still 1.
- Peak/clear: send 17'h00010, then 17'h1FF00 (mag 16'h0100), then 17'h00005 -> `peak` = 16'h0100. Pulse `clear` with `in_valid` = 0 -> `peak` = 0 and `sat_sticky` = 0. Pulse `clear` with `in_valid` = 1 and `in` = 17'h00007 -> `peak` = 7.
- Valid gating: drive `in_valid` low while `in` changes -> `out` holds its last value, `out_valid` = 0. Streaming 4 consecutive valid samples -> 4 consecutive `out_valid` cycles, each value matching its input 1 cycle later.

Source files
------------

// File: rtl/fir_magnitude.sv
// Converts a signed FIR accumulator sample into an unsigned magnitude.
// The output is registered, and the block also keeps sticky saturation and peak-magnitude status.
module fir_magnitude #(
   parameter int IN_WIDTH  = 17,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [IN_WIDTH-1:0]  in,
   input  logic                 in_valid,
   input  logic                 clear,
   output logic [OUT_WIDTH-1:0] out,
   output logic                 out_valid,
   output logic                 sat,
   output logic                 sat_sticky,
   output logic [OUT_WIDTH-1:0] peak
);

   localparam logic [IN_WIDTH-1:0] MOST_NEG = {1'b1, {(IN_WIDTH-1){1'b0}}};
   localparam logic [IN_WIDTH-1:0] ONE_IN   = {{(IN_WIDTH-1){1'b0}}, 1'b1};

   logic [IN_WIDTH-1:0]  neg_s;
   logic [OUT_WIDTH-1:0] mag_s;
   logic                 sat_now_s;

   logic [OUT_WIDTH-1:0] out_r,  out_nxt_s;
   logic                 out_valid_r, out_valid_nxt_s;
   logic                 sat_r, sat_nxt_s;
   logic                 sat_sticky_r, sat_sticky_nxt_s;
   logic [OUT_WIDTH-1:0] peak_r, peak_nxt_s;

   // Absolute value. -2^(IN_WIDTH-1) has no representable magnitude, so it is clamped to all ones.
   always_comb begin
      neg_s     = (~in) + ONE_IN;
      mag_s     = in[OUT_WIDTH-1:0];
      sat_now_s = 1'b0;
      if (in == MOST_NEG) begin
         mag_s     = {OUT_WIDTH{1'b1}};
         sat_now_s = 1'b1;
      end else if (in[IN_WIDTH-1]) begin
         mag_s     = neg_s[OUT_WIDTH-1:0];
      end else begin
         mag_s     = in[OUT_WIDTH-1:0];
      end
   end

   // Next-state logic. When clear and a valid sample arrive together, the new sample's status replaces the old status.
   always_comb begin
      out_nxt_s        = out_r;
      out_valid_nxt_s  = 1'b0;
      sat_nxt_s        = 1'b0;
      sat_sticky_nxt_s = sat_sticky_r;
      peak_nxt_s       = peak_r;
      if (in_valid) begin
         out_nxt_s       = mag_s;
         out_valid_nxt_s = 1'b1;
         sat_nxt_s       = sat_now_s;
         if (clear) begin
            peak_nxt_s       = mag_s;
            sat_sticky_nxt_s = sat_now_s;
         end else begin
            peak_nxt_s       = (mag_s > peak_r) ? mag_s : peak_r;
            sat_sticky_nxt_s = sat_sticky_r | sat_now_s;
         end
      end else begin
         if (clear) begin
            peak_nxt_s       = {OUT_WIDTH{1'b0}};
            sat_sticky_nxt_s = 1'b0;
         end else begin
            peak_nxt_s       = peak_r;
            sat_sticky_nxt_s = sat_sticky_r;
         end
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_r        <= {OUT_WIDTH{1'b0}};
         out_valid_r  <= 1'b0;
         sat_r        <= 1'b0;
         sat_sticky_r <= 1'b0;
         peak_r       <= {OUT_WIDTH{1'b0}};
      end else begin
         out_r        <= out_nxt_s;
         out_valid_r  <= out_valid_nxt_s;
         sat_r        <= sat_nxt_s;
         sat_sticky_r <= sat_sticky_nxt_s;
         peak_r       <= peak_nxt_s;
      end
   end

   assign out        = out_r;
   assign out_valid  = out_valid_r;
   assign sat        = sat_r;
   assign sat_sticky = sat_sticky_r;
   assign peak       = peak_r;

endmodule

// File: tb/tb_fir_magnitude.sv
// Directed bench for fir_magnitude. Expected magnitudes are placed in a queue when samples are driven
// and compared when out_valid appears. Peak and sticky status are tracked by a reference model.
module tb_fir_magnitude;

   logic        clk;
   logic        n_rst;
   logic [16:0] din;
   logic        din_valid;
   logic        clr;
   logic [15:0] dout;
   logic        dout_valid;
   logic        sat;
   logic        sat_sticky;
   logic [15:0] peak;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] mag;
      logic        sat;
   } exp_t;
   exp_t q[$];

   logic [15:0] m_out;
   logic [15:0] m_peak;
   logic        m_sticky;

   fir_magnitude dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .in         (din),
      .in_valid   (din_valid),
      .clear      (clr),
      .out        (dout),
      .out_valid  (dout_valid),
      .sat        (sat),
      .sat_sticky (sat_sticky),
      .peak       (peak)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference magnitude computed with integer arithmetic. Bit 16 of the result is the saturation flag.
   function automatic logic [16:0] ref_mag(input logic [16:0] v);
      int s;
      int a;
      s = int'($signed(v));
      a = (s < 0) ? -s : s;
      if (a > 65535) return {1'b1, 16'hFFFF};
      return {1'b0, a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_out    = 16'h0000;
      m_peak   = 16'h0000;
      m_sticky = 1'b0;
   endtask

   // Drive one cycle of stimulus, update the model, then check just after the clock edge.
   task automatic cycle(input string tag, input logic [16:0] v, input logic vld, input logic c);
      logic [16:0] r;
      exp_t e;
      din       = v;
      din_valid = vld;
      clr       = c;
      r = ref_mag(v);
      if (vld) begin
         e.mag = r[15:0];
         e.sat = r[16];
         q.push_back(e);
         m_out = r[15:0];
         if (c) begin
            m_peak   = r[15:0];
            m_sticky = r[16];
         end else begin
            if (r[15:0] > m_peak) m_peak = r[15:0];
            if (r[16]) m_sticky = 1'b1;
         end
      end else if (c) begin
         m_peak   = 16'h0000;
         m_sticky = 1'b0;
      end
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, {15'd0, dout_valid}, {15'd0, vld});
      if (dout_valid) begin
         chk({tag, ".queue_nonempty"}, {15'd0, (q.size() != 0)}, 16'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, ".out"}, dout, e.mag);
            chk({tag, ".sat"}, {15'd0, sat}, {15'd0, e.sat});
         end
      end else begin
         chk({tag, ".out_hold"}, dout, m_out);
         chk({tag, ".sat_idle"}, {15'd0, sat}, 16'd0);
      end
      chk({tag, ".peak"}, peak, m_peak);
      chk({tag, ".sat_sticky"}, {15'd0, sat_sticky}, {15'd0, m_sticky});
      din_valid = 1'b0;
      clr       = 1'b0;
   endtask

   initial begin
      model_reset();
      n_rst     = 1'b0;
      din       = 17'h0D6B5;
      din_valid = 1'b1;
      clr       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out", dout, 16'h0000);
      chk("rst.out_valid", {15'd0, dout_valid}, 16'd0);
      chk("rst.peak", peak, 16'h0000);
      chk("rst.sat_sticky", {15'd0, sat_sticky}, 16'd0);
      chk("rst.sat", {15'd0, sat}, 16'd0);
      @(negedge clk);
      n_rst = 1'b1;

      cycle("pos", 17'h0D6B5, 1'b1, 1'b0);
      cycle("neg", 17'h15555, 1'b1, 1'b0);
      chk("neg.literal", dout, 16'hAAAB);
      cycle("m1", 17'h1FFFF, 1'b1, 1'b0);
      chk("m1.literal", dout, 16'h0001);
      cycle("zero", 17'h00000, 1'b1, 1'b0);
      cycle("satv", 17'h10000, 1'b1, 1'b0);
      chk("satv.literal", dout, 16'hFFFF);
      chk("satv.flag", {15'd0, sat}, 16'd1);
      cycle("after_sat", 17'h00001, 1'b1, 1'b0);
      chk("after_sat.sticky", {15'd0, sat_sticky}, 16'd1);

      cycle("clr0", 17'h00000, 1'b0, 1'b1);
      cycle("pk1", 17'h00010, 1'b1, 1'b0);
      cycle("pk2", 17'h1FF00, 1'b1, 1'b0);
      cycle("pk3", 17'h00005, 1'b1, 1'b0);
      chk("pk.literal", peak, 16'h0100);
      cycle("clr1", 17'h00000, 1'b0, 1'b1);
      chk("clr1.literal", peak, 16'h0000);
      cycle("sat2", 17'h10000, 1'b1, 1'b0);
      cycle("clr_v", 17'h00007, 1'b1, 1'b1);
      chk("clr_v.literal", peak, 16'h0007);

      cycle("gate1", 17'h12345, 1'b0, 1'b0);
      cycle("gate2", 17'h0BEEF, 1'b0, 1'b0);
      chk("gate.literal", dout, 16'h0007);

      for (int i = 0; i < 4; i++) begin
         cycle("stream", 17'($urandom_range(0, 131071)), 1'b1, 1'b0);
      end
      cycle("stream_sat", 17'h10000, 1'b1, 1'b0);
      cycle("stream_end", 17'h00000, 1'b0, 1'b0);

      // Asynchronous reset between clock edges.
      cycle("pre_rst", 17'h0ABCD, 1'b1, 1'b0);
      din       = 17'h1FFF0;
      din_valid = 1'b1;
      @(posedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      model_reset();
      chk("arst.out", dout, 16'h0000);
      chk("arst.out_valid", {15'd0, dout_valid}, 16'd0);
      chk("arst.peak", peak, 16'h0000);
      chk("arst.sat_sticky", {15'd0, sat_sticky}, 16'd0);
      din_valid = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      cycle("post_rst", 17'h00000, 1'b0, 1'b0);
      cycle("post_rst_v", 17'h1FFFD, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
